// File: rtl/gumnut_alu_pkg.sv
// Shared definitions for the sequential Gumnut ALU: function codes,
// handshake FSM states and the shift/rotate sub-operation encoding.
package gumnut_alu_pkg;

  localparam logic [3:0] FN_ADD  = 4'd0;
  localparam logic [3:0] FN_ADDC = 4'd1;
  localparam logic [3:0] FN_SUB  = 4'd2;
  localparam logic [3:0] FN_SUBC = 4'd3;
  localparam logic [3:0] FN_AND  = 4'd4;
  localparam logic [3:0] FN_OR   = 4'd5;
  localparam logic [3:0] FN_XOR  = 4'd6;
  localparam logic [3:0] FN_MASK = 4'd7;
  localparam logic [3:0] FN_SHL  = 4'd8;
  localparam logic [3:0] FN_SHR  = 4'd9;
  localparam logic [3:0] FN_ROL  = 4'd10;
  localparam logic [3:0] FN_ROR  = 4'd11;
  localparam logic [3:0] FN_MUL  = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_MUL
  } state_t;

  // Low two bits of the shift/rotate function codes map directly onto this.
  typedef enum logic [1:0] {
    SH_SHL = 2'd0,
    SH_SHR = 2'd1,
    SH_ROL = 2'd2,
    SH_ROR = 2'd3
  } shift_op_t;

endpackage

// File: rtl/gumnut_alu_iter.sv
// Iterative datapath: one-bit-per-cycle shift/rotate register, shift-add
// multiply accumulator and the shared iteration down-counter.
module gumnut_alu_iter
  import gumnut_alu_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load,
  input  logic             step,
  input  shift_op_t        shift_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [CW:0]      count,
  output logic [WIDTH-1:0] sh_nxt,
  output logic             c_nxt,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt,
  output logic             last
);

  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] m_q;
  logic [CW:0]      cnt_q;
  shift_op_t        op_q;
  logic [WIDTH:0]   acc_sum;

  // Next shift-register value and the bit that leaves (or wraps) this step.
  always_comb begin
    sh_nxt = sh_q;
    c_nxt  = 1'b0;
    case (op_q)
      SH_SHL: begin
        sh_nxt = {sh_q[WIDTH-2:0], 1'b0};
        c_nxt  = sh_q[WIDTH-1];
      end
      SH_SHR: begin
        sh_nxt = {1'b0, sh_q[WIDTH-1:1]};
        c_nxt  = sh_q[0];
      end
      SH_ROL: begin
        sh_nxt = {sh_q[WIDTH-2:0], sh_q[WIDTH-1]};
        c_nxt  = sh_q[WIDTH-1];
      end
      SH_ROR: begin
        sh_nxt = {sh_q[0], sh_q[WIDTH-1:1]};
        c_nxt  = sh_q[0];
      end
      default: begin
        sh_nxt = sh_q;
        c_nxt  = 1'b0;
      end
    endcase
  end

  // Shift-add step: conditionally add the multiplicand into the high half,
  // then shift the whole {hi, lo} pair right, retiring one multiplier bit.
  always_comb begin
    acc_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
    hi_nxt  = acc_sum[WIDTH:1];
    lo_nxt  = {acc_sum[0], lo_q[WIDTH-1:1]};
  end

  assign last = (cnt_q == {{CW{1'b0}}, 1'b1});

  // Load operands at acceptance, then advance both datapaths on every step.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sh_q  <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      m_q   <= '0;
      cnt_q <= '0;
      op_q  <= SH_SHL;
    end else if (load) begin
      sh_q  <= a;
      m_q   <= a;
      lo_q  <= b;
      hi_q  <= '0;
      cnt_q <= count;
      op_q  <= shift_op;
    end else if (step) begin
      sh_q  <= sh_nxt;
      hi_q  <= hi_nxt;
      lo_q  <= lo_nxt;
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/gumnut_seq_alu.sv
// Multi-cycle Gumnut ALU: request/ready handshake, single-cycle arithmetic
// and logic, iterative shift/rotate/multiply, internal condition codes.
module gumnut_seq_alu
  import gumnut_alu_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  output logic             ready_o,
  input  logic [3:0]       fn_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic             done_o,
  output logic             cc_c_o,
  output logic             cc_z_o
);

  state_t           state_q;
  logic             accept;
  logic [CW-1:0]    sh_cnt;
  logic [CW:0]      iter_count;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_flags;
  logic             alu_single;

  logic [WIDTH-1:0] sh_nxt;
  logic             c_nxt;
  logic [WIDTH-1:0] hi_nxt;
  logic [WIDTH-1:0] lo_nxt;
  logic             last;

  assign ready_o    = (state_q == ST_IDLE);
  assign accept     = req_i && ready_o;
  assign sh_cnt     = b_i[CW-1:0];
  assign iter_count = (fn_i == FN_MUL) ? (CW+1)'(WIDTH) : {1'b0, sh_cnt};

  // Single-cycle result and carry; also decides whether the op needs iterating.
  always_comb begin
    sum_ext    = '0;
    alu_res    = a_i;
    alu_c      = 1'b0;
    alu_flags  = 1'b1;
    alu_single = 1'b1;
    case (fn_i)
      FN_ADD: begin
        sum_ext = {1'b0, a_i} + {1'b0, b_i};
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
      end
      FN_ADDC: begin
        sum_ext = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cc_c_o};
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
      end
      FN_SUB: begin
        sum_ext = {1'b0, a_i} - {1'b0, b_i};
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
      end
      FN_SUBC: begin
        sum_ext = {1'b0, a_i} - {1'b0, b_i} - {{WIDTH{1'b0}}, cc_c_o};
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
      end
      FN_AND:  alu_res = a_i & b_i;
      FN_OR:   alu_res = a_i | b_i;
      FN_XOR:  alu_res = a_i ^ b_i;
      FN_MASK: alu_res = a_i & ~b_i;
      FN_SHL, FN_SHR, FN_ROL, FN_ROR: alu_single = (sh_cnt == '0);
      FN_MUL:  alu_single = 1'b0;
      default: alu_flags = 1'b0;
    endcase
  end

  gumnut_alu_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load     (accept),
    .step     (state_q != ST_IDLE),
    .shift_op (shift_op_t'(fn_i[1:0])),
    .a        (a_i),
    .b        (b_i),
    .count    (iter_count),
    .sh_nxt   (sh_nxt),
    .c_nxt    (c_nxt),
    .hi_nxt   (hi_nxt),
    .lo_nxt   (lo_nxt),
    .last     (last)
  );

  // Handshake FSM with registered result, completion pulse and flags.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      result_o    <= '0;
      result_hi_o <= '0;
      done_o      <= 1'b0;
      cc_c_o      <= 1'b0;
      cc_z_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_i) begin
            if (alu_single) begin
              result_o    <= alu_res;
              result_hi_o <= '0;
              done_o      <= 1'b1;
              if (alu_flags) begin
                cc_c_o <= alu_c;
                cc_z_o <= (alu_res == '0);
              end
            end else if (fn_i == FN_MUL) begin
              state_q <= ST_MUL;
            end else begin
              state_q     <= ST_SHIFT;
              result_hi_o <= '0;
            end
          end
        end
        ST_SHIFT: begin
          result_o <= sh_nxt;
          if (last) begin
            state_q <= ST_IDLE;
            done_o  <= 1'b1;
            cc_c_o  <= c_nxt;
            cc_z_o  <= (sh_nxt == '0);
          end
        end
        ST_MUL: begin
          result_o    <= lo_nxt;
          result_hi_o <= hi_nxt;
          if (last) begin
            state_q <= ST_IDLE;
            done_o  <= 1'b1;
            cc_c_o  <= (hi_nxt != '0);
            cc_z_o  <= (hi_nxt == '0) && (lo_nxt == '0);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gumnut_seq_alu.sv
// Scoreboard bench for gumnut_seq_alu: directed ops push expected responses,
// a monitor pops and compares them on every done_o pulse.
module tb_gumnut_seq_alu;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       req_i;
  logic       ready_o;
  logic [3:0] fn_i;
  logic [7:0] a_i;
  logic [7:0] b_i;
  logic [7:0] result_o;
  logic [7:0] result_hi_o;
  logic       done_o;
  logic       cc_c_o;
  logic       cc_z_o;

  typedef struct {
    logic [7:0] res;
    logic [7:0] hi;
    logic       c;
    logic       z;
    int         cyc;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  mon_e;
  string mon_n;
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;

  gumnut_seq_alu #(.WIDTH(8)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .ready_o     (ready_o),
    .fn_i        (fn_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .result_o    (result_o),
    .result_hi_o (result_hi_o),
    .done_o      (done_o),
    .cc_c_o      (cc_c_o),
    .cc_z_o      (cc_z_o)
  );

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  // Edge counter used to time each completion.
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (rst_i === 1'b1 && done_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_n = name_q.pop_front();
        checkOutput({mon_n, "_res"},   result_o,    mon_e.res);
        checkOutput({mon_n, "_hi"},    result_hi_o, mon_e.hi);
        checkOutput({mon_n, "_c"},     cc_c_o,      mon_e.c);
        checkOutput({mon_n, "_z"},     cc_z_o,      mon_e.z);
        checkOutput({mon_n, "_cycle"}, cyc,         mon_e.cyc);
      end
    end
  end

  task automatic waitReady(input string name);
    int guard;
    guard = 0;
    while (ready_o !== 1'b1 && guard < 40) begin
      @(negedge clk_i);
      guard++;
    end
    if (guard >= 40) checkOutput({name, "_ready_timeout"}, 32'd1, 32'd0);
  endtask

  // Issue one op, record its expected response, and watch ready_o while busy.
  task automatic applyStimulus(input logic [3:0] fn, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] e_res, input logic [7:0] e_hi,
                               input logic e_c, input logic e_z, input int lat, input string name);
    exp_t e;
    @(negedge clk_i);
    waitReady(name);
    req_i = 1'b1;
    fn_i  = fn;
    a_i   = a;
    b_i   = b;
    e.res = e_res;
    e.hi  = e_hi;
    e.c   = e_c;
    e.z   = e_z;
    e.cyc = cyc + 1 + lat;
    exp_q.push_back(e);
    name_q.push_back(name);
    @(negedge clk_i);
    req_i = 1'b0;
    for (int i = 0; i < lat; i++) begin
      checkOutput({name, "_busy"}, ready_o, 1'b0);
      @(negedge clk_i);
    end
    checkOutput({name, "_ready_after"}, ready_o, 1'b1);
  endtask

  initial begin
    exp_t e;
    int   guard;
    rst_i = 1'b0;
    req_i = 1'b0;
    fn_i  = 4'd0;
    a_i   = 8'h00;
    b_i   = 8'h00;
    repeat (3) @(negedge clk_i);
    checkOutput("rst_ready",  ready_o,     1'b1);
    checkOutput("rst_done",   done_o,      1'b0);
    checkOutput("rst_result", result_o,    8'h00);
    checkOutput("rst_hi",     result_hi_o, 8'h00);
    checkOutput("rst_c",      cc_c_o,      1'b0);
    checkOutput("rst_z",      cc_z_o,      1'b0);
    rst_i = 1'b1;

    //             fn     a      b      res    hi     c     z     lat name
    applyStimulus(4'd0,  8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 0, "add");
    applyStimulus(4'd1,  8'h00, 8'h00, 8'h01, 8'h00, 1'b0, 1'b0, 0, "addc");
    applyStimulus(4'd2,  8'h05, 8'h10, 8'hF5, 8'h00, 1'b1, 1'b0, 0, "sub");
    applyStimulus(4'd3,  8'h10, 8'h05, 8'h0A, 8'h00, 1'b0, 1'b0, 0, "subc");
    applyStimulus(4'd11, 8'h81, 8'h03, 8'h30, 8'h00, 1'b0, 1'b0, 3, "ror3");
    applyStimulus(4'd8,  8'h81, 8'h01, 8'h02, 8'h00, 1'b1, 1'b0, 1, "shl1");
    applyStimulus(4'd9,  8'h33, 8'h00, 8'h33, 8'h00, 1'b0, 1'b0, 0, "shr0");
    applyStimulus(4'd4,  8'hF0, 8'h0F, 8'h00, 8'h00, 1'b0, 1'b1, 0, "and");
    applyStimulus(4'd7,  8'hFF, 8'h0F, 8'hF0, 8'h00, 1'b0, 1'b0, 0, "mask");
    applyStimulus(4'd10, 8'hC0, 8'h02, 8'h03, 8'h00, 1'b1, 1'b0, 2, "rol2");
    applyStimulus(4'd12, 8'h0F, 8'h11, 8'hFF, 8'h00, 1'b0, 1'b0, 8, "mul_a");

    // Multiply with req_i held high throughout: the busy-time requests must be ignored.
    @(negedge clk_i);
    waitReady("mul_b");
    req_i = 1'b1;
    fn_i  = 4'd12;
    a_i   = 8'h80;
    b_i   = 8'h04;
    e.res = 8'h00;
    e.hi  = 8'h02;
    e.c   = 1'b1;
    e.z   = 1'b0;
    e.cyc = cyc + 1 + 8;
    exp_q.push_back(e);
    name_q.push_back("mul_b");
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      checkOutput("mul_b_busy", ready_o, 1'b0);
    end
    @(negedge clk_i);
    req_i = 1'b0;
    checkOutput("mul_b_ready_after", ready_o, 1'b1);
    repeat (3) @(negedge clk_i);

    applyStimulus(4'd13, 8'h5A, 8'hFF, 8'h5A, 8'h00, 1'b1, 1'b0, 0, "reserved");

    // Reset four cycles into a multiply: everything clears at once, no completion.
    @(negedge clk_i);
    waitReady("rst_mul");
    req_i = 1'b1;
    fn_i  = 4'd12;
    a_i   = 8'hFF;
    b_i   = 8'hFF;
    @(negedge clk_i);
    req_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    checkOutput("midrst_ready",  ready_o,     1'b1);
    checkOutput("midrst_done",   done_o,      1'b0);
    checkOutput("midrst_result", result_o,    8'h00);
    checkOutput("midrst_hi",     result_hi_o, 8'h00);
    checkOutput("midrst_c",      cc_c_o,      1'b0);
    checkOutput("midrst_z",      cc_z_o,      1'b0);
    repeat (4) @(negedge clk_i);
    rst_i = 1'b1;

    applyStimulus(4'd0, 8'h01, 8'h02, 8'h03, 8'h00, 1'b0, 1'b0, 0, "add_post_rst");

    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(negedge clk_i);
      guard++;
    end
    checkOutput("queue_drained", exp_q.size(), 32'd0);
    repeat (5) @(negedge clk_i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so a stuck DUT can never hang the run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
